// File: rtl/riscv_run_monitor_if.sv
// Purpose: core-side observation bundle (pc, retiring instr, writeback) feeding the run monitor.
// Latency: wires only, no storage.
// Backpressure: none; the core drives and the monitor only observes.
// Ports (modports):
//   master - core side, drives pc, instr, instr_valid, regwrite, rd, wdata
//   slave  - monitor side, samples the same signals
interface riscv_run_monitor_if #(
  parameter int XLEN = 32
) ();
  logic [XLEN-1:0] pc;
  logic [31:0]     instr;
  logic            instr_valid;
  logic            regwrite;
  logic [4:0]      rd;
  logic [XLEN-1:0] wdata;

  modport master (output pc, output instr, output instr_valid,
                  output regwrite, output rd, output wdata);
  modport slave  (input  pc, input  instr, input  instr_valid,
                  input  regwrite, input  rd, input  wdata);
endinterface

// File: rtl/riscv_run_monitor.sv
// Purpose: run-control / trace monitor for the multi-cycle RV32I core (halt, timeout, writeback trace).
// Latency: state, counters and done/timed_out update on the edge after the deciding cycle; trace_data is combinational.
// Backpressure: none; purely observes the core and never stalls it.
// Ports:
//   clk, reset     rising-edge clock, synchronous active-high reset
//   start          1-cycle pulse, arms / re-arms a run from IDLE, HALTED or TIMEOUT
//   core           riscv_run_monitor_if.slave: pc, instr, instr_valid, regwrite, rd, wdata
//   run_state      0 IDLE, 1 RUN, 2 HALTED, 3 TIMEOUT
//   done/timed_out registered status flags for HALTED / TIMEOUT
//   cycle_count, retired_count, last_pc   run statistics (saturating counters)
//   trace_count, trace_idx, trace_data    circular writeback trace, idx 0 = newest
// Optional build macro RUN_MON_CHECK_EN adds exp_valid/exp_rd/exp_data inputs and
// mismatch/mismatch_count outputs that compare each captured writeback against a reference.
module riscv_run_monitor #(
  parameter int          XLEN           = 32,
  parameter int          TRACE_DEPTH    = 8,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] HALT_INSTR     = 32'h0000006f
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  riscv_run_monitor_if.slave             core,
  output logic [1:0]                     run_state,
  output logic                           done,
  output logic                           timed_out,
  output logic [31:0]                    cycle_count,
  output logic [31:0]                    retired_count,
  output logic [XLEN-1:0]                last_pc,
  output logic [$clog2(TRACE_DEPTH):0]   trace_count,
  input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
  output logic [5+XLEN-1:0]              trace_data
`ifdef RUN_MON_CHECK_EN
  ,
  input  logic                           exp_valid,
  input  logic [4:0]                     exp_rd,
  input  logic [XLEN-1:0]                exp_data,
  output logic                           mismatch,
  output logic [15:0]                    mismatch_count
`else
`endif
);

  localparam int PW = $clog2(TRACE_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_HALTED  = 2'd2,
    S_TIMEOUT = 2'd3
  } state_t;

  state_t state_q, state_n;
  logic   clear_run;   // start accepted: wipe all run statistics on this edge
  logic   in_run;
  logic   halt_hit;
  logic   capture;

  logic [PW-1:0]      wr_ptr;
  logic [5+XLEN-1:0]  trace_mem [TRACE_DEPTH];
  logic [PW-1:0]      rd_ptr;

  assign in_run   = (state_q == S_RUN);
  assign halt_hit = in_run && core.instr_valid && (core.instr == HALT_INSTR);
  // Gated by reset so a mid-run reset leaves nothing behind in the trace.
  assign capture  = in_run && !reset && core.regwrite && (core.rd != 5'd0);

  // Next-state: halt has priority over timeout on the same cycle; start is only
  // honoured outside RUN.
  always_comb begin
    state_n   = state_q;
    clear_run = 1'b0;
    unique case (state_q)
      S_RUN: begin
        if (halt_hit)
          state_n = S_HALTED;
        else if (cycle_count == 32'(TIMEOUT_CYCLES - 1))
          state_n = S_TIMEOUT;
      end
      default: begin
        if (start) begin
          state_n   = S_RUN;
          clear_run = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      done          <= 1'b0;
      timed_out     <= 1'b0;
      cycle_count   <= '0;
      retired_count <= '0;
      last_pc       <= '0;
      trace_count   <= '0;
      wr_ptr        <= '0;
    end else begin
      state_q   <= state_n;
      done      <= (state_n == S_HALTED);
      timed_out <= (state_n == S_TIMEOUT);
      if (clear_run) begin
        cycle_count   <= '0;
        retired_count <= '0;
        last_pc       <= '0;
        trace_count   <= '0;
        wr_ptr        <= '0;
      end else if (in_run) begin
        if (cycle_count != 32'hFFFF_FFFF)
          cycle_count <= cycle_count + 32'd1;
        if (core.instr_valid) begin
          if (retired_count != 32'hFFFF_FFFF)
            retired_count <= retired_count + 32'd1;
          last_pc <= core.pc;
        end
        if (capture) begin
          wr_ptr <= wr_ptr + PW'(1);   // power-of-2 depth: natural wrap
          if (trace_count != CW'(TRACE_DEPTH))
            trace_count <= trace_count + CW'(1);
        end
      end
    end
  end

  // Trace storage needs no reset: entries beyond trace_count are never visible.
  always_ff @(posedge clk) begin
    if (capture)
      trace_mem[wr_ptr] <= {core.rd, core.wdata};
  end

  // Newest entry sits just behind the write pointer.
  assign rd_ptr     = wr_ptr - PW'(1) - trace_idx;
  assign trace_data = ({1'b0, trace_idx} < trace_count) ? trace_mem[rd_ptr] : '0;
  assign run_state  = state_q;

`ifdef RUN_MON_CHECK_EN
  logic miss;
  assign miss = capture && exp_valid &&
                ((exp_rd != core.rd) || (exp_data != core.wdata));

  always_ff @(posedge clk) begin
    if (reset || clear_run) begin
      mismatch       <= 1'b0;
      mismatch_count <= '0;
    end else begin
      mismatch <= miss;
      if (miss && (mismatch_count != 16'hFFFF))
        mismatch_count <= mismatch_count + 16'd1;
    end
  end
`else
  // Reference comparison not built.
`endif

endmodule

// File: tb/tb_riscv_run_monitor.sv
// Purpose: directed self-checking bench for riscv_run_monitor (reset, halt, timeout, trace, check port).
// Latency: inputs driven 1 ns after a rising edge, outputs sampled in the same window.
// Backpressure: n/a.
module tb_riscv_run_monitor;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  run_state;
  logic        done;
  logic        timed_out;
  logic [31:0] cycle_count;
  logic [31:0] retired_count;
  logic [31:0] last_pc;
  logic [3:0]  trace_count;
  logic [2:0]  trace_idx;
  logic [36:0] trace_data;
`ifdef RUN_MON_CHECK_EN
  logic        exp_valid;
  logic [4:0]  exp_rd;
  logic [31:0] exp_data;
  logic        mismatch;
  logic [15:0] mismatch_count;
`endif

  localparam logic [31:0] HALT = 32'h0000006f;
  localparam logic [31:0] NOP  = 32'h00000013;
  localparam logic [31:0] ADDI = 32'h00500693;  // addi x13,x0,5

  riscv_run_monitor_if #(.XLEN(32)) core_if ();

  riscv_run_monitor dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .core          (core_if),
    .run_state     (run_state),
    .done          (done),
    .timed_out     (timed_out),
    .cycle_count   (cycle_count),
    .retired_count (retired_count),
    .last_pc       (last_pc),
    .trace_count   (trace_count),
    .trace_idx     (trace_idx),
    .trace_data    (trace_data)
`ifdef RUN_MON_CHECK_EN
    ,
    .exp_valid     (exp_valid),
    .exp_rd        (exp_rd),
    .exp_data      (exp_data),
    .mismatch      (mismatch),
    .mismatch_count(mismatch_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] te(input int r, input int d);
    logic [4:0]  r5;
    logic [31:0] d32;
    r5  = 5'(r);
    d32 = 32'(d);
    return 64'({r5, d32});
  endfunction

  task automatic chk_trace(input string tag, input int idx, input logic [63:0] exp);
    trace_idx = 3'(idx);
    #1;
    check(tag, 64'(trace_data), exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    core_if.instr_valid = 1'b0;
    core_if.regwrite    = 1'b0;
    core_if.rd          = 5'd0;
    core_if.wdata       = 32'd0;
    core_if.instr       = NOP;
`ifdef RUN_MON_CHECK_EN
    exp_valid = 1'b0;
    exp_rd    = 5'd0;
    exp_data  = 32'd0;
`endif
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    trace_idx  = 3'd0;
    core_if.pc = 32'd0;
    idle_in();

    // 1: reset
    repeat (4) step();
    reset = 1'b0;
    step();
    check("rst_state",   64'(run_state), 64'd0);
    check("rst_done",    64'(done), 64'd0);
    check("rst_tmo",     64'(timed_out), 64'd0);
    check("rst_cycles",  64'(cycle_count), 64'd0);
    check("rst_retired", 64'(retired_count), 64'd0);
    check("rst_lastpc",  64'(last_pc), 64'd0);
    check("rst_tcount",  64'(trace_count), 64'd0);
    for (int i = 0; i < 8; i++) chk_trace("rst_trace", i, 64'd0);

    // 2: addi then halt
    pulse_start();
    check("t2_state_run", 64'(run_state), 64'd1);
    core_if.pc = 32'd0; core_if.instr = ADDI; core_if.instr_valid = 1'b1;
    core_if.regwrite = 1'b1; core_if.rd = 5'd13; core_if.wdata = 32'd5;
    step();
    core_if.pc = 32'd4; core_if.instr = HALT; core_if.instr_valid = 1'b1;
    core_if.regwrite = 1'b0; core_if.rd = 5'd0; core_if.wdata = 32'd0;
    step();
    idle_in();
    check("t2_state",   64'(run_state), 64'd2);
    check("t2_done",    64'(done), 64'd1);
    check("t2_tmo",     64'(timed_out), 64'd0);
    check("t2_retired", 64'(retired_count), 64'd2);
    check("t2_cycles",  64'(cycle_count), 64'd2);
    check("t2_lastpc",  64'(last_pc), 64'd4);
    check("t2_tcount",  64'(trace_count), 64'd1);
    chk_trace("t2_idx0", 0, te(13, 5));
    chk_trace("t2_idx1_empty", 1, 64'd0);
    repeat (3) step();
    check("t2_frozen_cycles",  64'(cycle_count), 64'd2);
    check("t2_frozen_retired", 64'(retired_count), 64'd2);

    // 3: timeout
    pulse_start();
    check("t3_done_clr",    64'(done), 64'd0);
    check("t3_retired_clr", 64'(retired_count), 64'd0);
    check("t3_tcount_clr",  64'(trace_count), 64'd0);
    check("t3_lastpc_clr",  64'(last_pc), 64'd0);
    repeat (1023) step();
    check("t3_state_1023",  64'(run_state), 64'd1);
    check("t3_cycles_1023", 64'(cycle_count), 64'd1023);
    check("t3_tmo_1023",    64'(timed_out), 64'd0);
    step();
    check("t3_state",  64'(run_state), 64'd3);
    check("t3_tmo",    64'(timed_out), 64'd1);
    check("t3_done",   64'(done), 64'd0);
    check("t3_cycles", 64'(cycle_count), 64'd1024);
    repeat (5) step();
    check("t3_frozen", 64'(cycle_count), 64'd1024);

    // 4: trace wrap, x0 write, start ignored in RUN, mid-run reset
    pulse_start();
    check("t4_tmo_clr", 64'(timed_out), 64'd0);
    for (int i = 1; i <= 10; i++) begin
      core_if.regwrite = 1'b1;
      core_if.rd       = 5'(i);
      core_if.wdata    = 32'(i * 3);
      step();
    end
    idle_in();
    check("t4_tcount", 64'(trace_count), 64'd8);
    check("t4_cycles", 64'(cycle_count), 64'd10);
    chk_trace("t4_idx0", 0, te(10, 30));
    chk_trace("t4_idx1", 1, te(9, 27));
    chk_trace("t4_idx7", 7, te(3, 9));
    core_if.regwrite = 1'b1; core_if.rd = 5'd0; core_if.wdata = 32'd99;
    step();
    idle_in();
    check("t4_x0_tcount", 64'(trace_count), 64'd8);
    chk_trace("t4_x0_idx0", 0, te(10, 30));
    pulse_start();
    check("t4_start_ign_state",  64'(run_state), 64'd1);
    check("t4_start_ign_cycles", 64'(cycle_count), 64'd12);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t4_mrst_state",   64'(run_state), 64'd0);
    check("t4_mrst_cycles",  64'(cycle_count), 64'd0);
    check("t4_mrst_tcount",  64'(trace_count), 64'd0);
    check("t4_mrst_lastpc",  64'(last_pc), 64'd0);
    check("t4_mrst_done",    64'(done), 64'd0);
    chk_trace("t4_mrst_idx0", 0, 64'd0);
    step();
    check("t4_mrst_idle", 64'(run_state), 64'd0);

    // 5: halt on the last cycle before timeout wins
    pulse_start();
    repeat (1023) step();
    check("t5_cycles_1023", 64'(cycle_count), 64'd1023);
    core_if.pc = 32'h100; core_if.instr = HALT; core_if.instr_valid = 1'b1;
    step();
    idle_in();
    check("t5_state",   64'(run_state), 64'd2);
    check("t5_done",    64'(done), 64'd1);
    check("t5_tmo",     64'(timed_out), 64'd0);
    check("t5_cycles",  64'(cycle_count), 64'd1024);
    check("t5_retired", 64'(retired_count), 64'd1);
    check("t5_lastpc",  64'(last_pc), 64'h100);

`ifdef RUN_MON_CHECK_EN
    // 6: reference comparison
    pulse_start();
    core_if.regwrite = 1'b1; core_if.rd = 5'd13; core_if.wdata = 32'd5;
    exp_valid = 1'b1; exp_rd = 5'd13; exp_data = 32'd6;
    step();
    check("t6_mis_pulse", 64'(mismatch), 64'd1);
    check("t6_mis_count", 64'(mismatch_count), 64'd1);
    core_if.wdata = 32'd7; exp_data = 32'd7;
    step();
    idle_in();
    check("t6_match_nopulse", 64'(mismatch), 64'd0);
    check("t6_match_count",   64'(mismatch_count), 64'd1);
    check("t6_tcount",        64'(trace_count), 64'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
